// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive frame controller.
//   - FSM state encodings (3-bit)
//   - parity type encodings
//   - parity check helper
package uart_rx_ctrl_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // data_xor is the XOR-reduce of the received data bits.
  // A result of 1 means the received parity bit does not match.
  function automatic logic parity_err(input logic data_xor, input logic par_bit,
                                      input logic par_typ);
    return data_xor ^ par_bit ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and data-bit counter for the UART receiver.
// Ports:
//   CLK, RST      clock, async active-low reset
//   en_i          advance the edge counter (wraps to 0 at bit end)
//   clr_i         force the edge counter to 0 (has priority over en_i)
//   data_i        high while in the DATA phase; bit counter is held at 0 otherwise
//   presc_i       latched oversampling ratio
//   edge_cnt_o    oversample index within the current bit
//   bit_end_o     edge_cnt_o == presc_i-1
//   bits_done_o   bit end of the last data bit
module uart_rx_edge_bit_counter
  import uart_rx_ctrl_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 5,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic                      data_i,
  input  logic [PRESCALE_WIDTH-1:0] presc_i,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt_o,
  output logic                      bit_end_o,
  output logic                      bits_done_o
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;

  logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
  logic [BW-1:0]             bit_q, bit_d;

  assign edge_cnt_o  = edge_q;
  assign bit_end_o   = (edge_q == presc_i - PRESCALE_WIDTH'(1));
  assign bits_done_o = data_i & bit_end_o & (bit_q == BW'(DATA_WIDTH - 1));

  always_comb begin
    edge_d = edge_q;
    if (clr_i)     edge_d = '0;
    else if (en_i) edge_d = bit_end_o ? '0 : edge_q + PRESCALE_WIDTH'(1);

    // Outside DATA the bit counter sits at 0, so DATA always starts at bit 0.
    bit_d = bit_q;
    if (!data_i)        bit_d = '0;
    else if (bit_end_o) bit_d = bit_q + BW'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller.
// Detects the start edge, drives Edge_Cnt/Sample_En for the external
// majority-vote sampler, deserialises Sampled_Bit LSB-first, checks parity
// and stop bit, and emits one-cycle Data_Valid / Par_Err / Stop_Err strobes.
// Ports:
//   CLK, RST        oversampling clock, async active-low reset
//   RX_IN           serial line (idle high)
//   Prescale        oversampling ratio (even, >= 8), latched per frame
//   PAR_EN/PAR_TYP  parity enable / type (0 even, 1 odd), latched per frame
//   Sampled_Bit     voted bit from the sampler
//   Sample_En       high whenever not IDLE
//   Edge_Cnt        oversample index within the current bit
//   P_DATA          last good frame's data
//   Data_Valid, Par_Err, Stop_Err   one-cycle result strobes
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 5,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      Sampled_Bit,
  output logic                      Sample_En,
  output logic [PRESCALE_WIDTH-1:0] Edge_Cnt,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      Data_Valid,
  output logic                      Par_Err,
  output logic                      Stop_Err
);

  logic [2:0]                state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] presc_q;
  logic                      par_en_q, par_typ_q;
  logic [DATA_WIDTH-1:0]     shift_q, pdata_q;
  logic                      err_p_q;
  logic                      dv_q, pe_q, se_q;

  logic start_det, decide, cnt_en, cnt_clr, in_data, bit_end, bits_done;
  logic par_bad;

  assign start_det = (state_q == S_IDLE) & ~RX_IN;
  // Stop decision is taken mid-bit so the line is back in IDLE well before
  // a back-to-back start edge can arrive.
  assign decide    = (state_q == S_STOP) &
                     (Edge_Cnt == (presc_q >> 1) + PRESCALE_WIDTH'(2));
  assign in_data   = (state_q == S_DATA);
  // The detect cycle is edge 0, so counting starts while still in IDLE.
  assign cnt_en    = (state_q != S_IDLE) | ~RX_IN;
  assign cnt_clr   = ((state_q == S_IDLE) & RX_IN) | decide;
  assign par_bad   = err_p_q & par_en_q;

  uart_rx_edge_bit_counter #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .data_i     (in_data),
    .presc_i    (presc_q),
    .edge_cnt_o (Edge_Cnt),
    .bit_end_o  (bit_end),
    .bits_done_o(bits_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!RX_IN)   state_d = S_START;
      S_START:  if (bit_end)  state_d = Sampled_Bit ? S_IDLE : S_DATA;
      S_DATA:   if (bits_done) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end)  state_d = S_STOP;
      S_STOP:   if (decide)   state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      shift_q   <= '0;
      pdata_q   <= '0;
      err_p_q   <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      se_q    <= 1'b0;
      if (start_det) begin
        presc_q   <= Prescale;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        err_p_q   <= 1'b0;
      end
      if (in_data && bit_end)
        shift_q <= {Sampled_Bit, shift_q[DATA_WIDTH-1:1]};
      if (state_q == S_PARITY && bit_end)
        err_p_q <= parity_err(^shift_q, Sampled_Bit, par_typ_q);
      if (decide) begin
        se_q <= ~Sampled_Bit;
        pe_q <= par_bad;
        dv_q <= Sampled_Bit & ~par_bad;
        if (Sampled_Bit && !par_bad) pdata_q <= shift_q;
      end
    end
  end

  assign Sample_En  = (state_q != S_IDLE);
  assign P_DATA     = pdata_q;
  assign Data_Valid = dv_q;
  assign Par_Err    = pe_q;
  assign Stop_Err   = se_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with an ideal sampler: Sampled_Bit equals
// the bit currently on the line for the whole bit period.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [4:0] Prescale;
  logic       PAR_EN, PAR_TYP, Sampled_Bit;
  logic       Sample_En, Data_Valid, Par_Err, Stop_Err;
  logic [4:0] Edge_Cnt;
  logic [7:0] P_DATA;

  int vecs = 0;
  int errs = 0;
  int psc  = 8;

  int   dv_n = 0, pe_n = 0, se_n = 0, wide_n = 0;
  logic dv_p = 1'b0, pe_p = 1'b0, se_p = 1'b0;

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.PRESCALE_WIDTH(5), .DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Sampled_Bit(Sampled_Bit),
    .Sample_En  (Sample_En),
    .Edge_Cnt   (Edge_Cnt),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stop_Err   (Stop_Err)
  );

  // Pulse counters; any strobe high on two consecutive cycles counts as wide.
  always @(negedge CLK) begin
    if (Data_Valid) dv_n++;
    if (Par_Err)    pe_n++;
    if (Stop_Err)   se_n++;
    if ((Data_Valid && dv_p) || (Par_Err && pe_p) || (Stop_Err && se_p)) wide_n++;
    dv_p = Data_Valid;
    pe_p = Par_Err;
    se_p = Stop_Err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive just after the rising edge, return at the falling edge.
  task automatic cyc(input logic rx, input logic sb);
    @(posedge CLK);
    #1;
    RX_IN       = rx;
    Sampled_Bit = sb;
    @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    repeat (psc) cyc(b, b);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic stopb, input logic edv, input logic epe,
                            input logic ese, input logic [7:0] epd);
    for (int k = 0; k < psc; k++) begin
      cyc(1'b0, 1'b0);
      if (k == 1) chk("start_edge_cnt", 32'(Edge_Cnt), 32'd1);
    end
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(pbit);
    for (int k = 0; k < psc; k++) begin
      cyc(stopb, stopb);
      if (k == psc / 2 + 3) begin
        chk("data_valid", 32'(Data_Valid), 32'(edv));
        chk("par_err",    32'(Par_Err),    32'(epe));
        chk("stop_err",   32'(Stop_Err),   32'(ese));
        chk("p_data",     32'(P_DATA),     32'(epd));
        chk("sample_en_after_stop", 32'(Sample_En), 32'd0);
        chk("edge_cnt_after_stop",  32'(Edge_Cnt),  32'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    RST = 1'b0; RX_IN = 1'b1; Sampled_Bit = 1'b1;
    Prescale = 5'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #3;
    chk("rst_sample_en", 32'(Sample_En),  32'd0);
    chk("rst_edge_cnt",  32'(Edge_Cnt),   32'd0);
    chk("rst_p_data",    32'(P_DATA),     32'd0);
    chk("rst_dv",        32'(Data_Valid), 32'd0);
    chk("rst_pe",        32'(Par_Err),    32'd0);
    chk("rst_se",        32'(Stop_Err),   32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    idle(4);

    // Good frame, no parity
    psc = 8; Prescale = 5'(psc);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    idle(4);
    chk("a5_dv_count", 32'(dv_n), 32'd1);

    // Even parity: correct then wrong parity bit
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h03);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03);
    idle(4);
    chk("par_dv_count", 32'(dv_n), 32'd2);
    chk("par_pe_count", 32'(pe_n), 32'd1);

    // Start glitch: line low 2 cycles, sampler votes 1
    PAR_EN = 1'b0;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    for (int k = 2; k <= 8; k++) begin
      cyc(1'b1, 1'b1);
      if (k == 7) begin
        chk("glitch_sample_en_busy", 32'(Sample_En), 32'd1);
        chk("glitch_edge_cnt_7",     32'(Edge_Cnt),  32'd7);
      end
      if (k == 8) begin
        chk("glitch_sample_en_idle", 32'(Sample_En), 32'd0);
        chk("glitch_edge_cnt_0",     32'(Edge_Cnt),  32'd0);
      end
    end
    idle(4);
    chk("glitch_no_strobes", 32'(dv_n + pe_n + se_n), 32'd3);

    // Stop error; the low stop bit re-triggers a start that then glitches out
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03);
    idle(20);
    chk("stop_se_count", 32'(se_n), 32'd1);
    chk("stop_dv_count", 32'(dv_n), 32'd2);
    chk("stop_idle",     32'(Sample_En), 32'd0);

    // Back-to-back frames at Prescale 16
    psc = 16; Prescale = 5'(psc);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
    send_frame(8'hEE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
    idle(4);
    chk("b2b_dv_count", 32'(dv_n), 32'd4);

    // Reset during data bit 4
    psc = 8; Prescale = 5'(psc);
    d = 8'h96;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    repeat (3) cyc(d[4], d[4]);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("mid_rst_sample_en", 32'(Sample_En),  32'd0);
    chk("mid_rst_edge_cnt",  32'(Edge_Cnt),   32'd0);
    chk("mid_rst_p_data",    32'(P_DATA),     32'd0);
    chk("mid_rst_strobes",   32'({Data_Valid, Par_Err, Stop_Err}), 32'd0);
    RX_IN = 1'b1; Sampled_Bit = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    idle(20);
    chk("post_rst_no_strobes", 32'(dv_n + pe_n + se_n), 32'd6);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
    idle(4);
    chk("final_dv_count", 32'(dv_n),   32'd5);
    chk("strobe_width",   32'(wide_n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
